// File: rtl/param_data_memory_if.sv
// CPU data-port bus for param_data_memory: request, write data, read data, stall and error.
// The CPU drives the master side and the memory takes the slave side.
interface param_data_memory_if #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int BLOCK_WORDS = 4
);
    logic                          READ;
    logic                          WRITE;
    logic                          BLOCK;
    logic [ADDR_W-1:0]             ADDRESS;
    logic [DATA_W*BLOCK_WORDS-1:0] WRITEDATA;
    logic [DATA_W*BLOCK_WORDS-1:0] READDATA;
    logic                          BUSYWAIT;
    logic                          ERROR;

    modport master (
        output READ, WRITE, BLOCK, ADDRESS, WRITEDATA,
        input  READDATA, BUSYWAIT, ERROR
    );

    modport slave (
        input  READ, WRITE, BLOCK, ADDRESS, WRITEDATA,
        output READDATA, BUSYWAIT, ERROR
    );
endinterface

// File: rtl/param_data_memory.sv
// Multi-cycle data memory with configurable width, depth and latency, plus aligned block access.
// The CPU is stalled via BUSYWAIT; a simultaneous READ and WRITE is rejected with an ERROR pulse.
module param_data_memory #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int LATENCY     = 5,
    parameter int BLOCK_WORDS = 4
) (
    input logic                CLK,
    input logic                RESET,
    param_data_memory_if.slave bus
);
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam int LINE_W = DATA_W * BLOCK_WORDS;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic               blk_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  rdata;
    logic               err;
    logic [DATA_W-1:0]  mem [2**ADDR_W];

    logic               finish;
    logic [ADDR_W-1:0]  base;

    assign finish = (state == BUSY) && (cnt == CNT_W'(LATENCY - 1));
    // Block accesses are aligned down so the burst never wraps past the top of memory.
    assign base   = addr_q & ~ADDR_W'(BLOCK_WORDS - 1);

    assign bus.BUSYWAIT = RESET && (((state == IDLE) && (bus.READ ^ bus.WRITE)) || (state == BUSY));
    assign bus.READDATA = rdata;
    assign bus.ERROR    = err;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            op_wr   <= 1'b0;
            blk_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    err <= bus.READ & bus.WRITE;
                    if (bus.READ ^ bus.WRITE) begin
                        op_wr   <= bus.WRITE;
                        blk_q   <= bus.BLOCK;
                        addr_q  <= bus.ADDRESS;
                        wdata_q <= bus.WRITEDATA;
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    err <= 1'b0;
                    cnt <= cnt + 1'b1;
                    if (finish) begin
                        state <= DONE;
                        if (!op_wr) begin
                            if (blk_q) begin
                                for (int i = 0; i < BLOCK_WORDS; i++)
                                    rdata[i*DATA_W +: DATA_W] <= mem[base | ADDR_W'(i)];
                            end else begin
                                rdata                <= '0;
                                rdata[DATA_W-1:0]    <= mem[addr_q];
                            end
                        end
                    end
                end
                DONE: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage has no reset; an aborted write never reaches here because reset leaves BUSY at once.
    always_ff @(posedge CLK) begin
        if (finish && op_wr) begin
            if (blk_q) begin
                for (int i = 0; i < BLOCK_WORDS; i++)
                    mem[base | ADDR_W'(i)] <= wdata_q[i*DATA_W +: DATA_W];
            end else begin
                mem[addr_q] <= wdata_q[DATA_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory at default parameters: vector table plus
// hand-written sequences for error, reset abort and held-request corner cases.
module tb_param_data_memory;
    logic clk;
    logic rst;

    param_data_memory_if #(.ADDR_W(8), .DATA_W(8), .BLOCK_WORDS(4)) bus ();

    param_data_memory #(
        .ADDR_W(8), .DATA_W(8), .LATENCY(5), .BLOCK_WORDS(4)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        blk;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];
    int   total = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Counts consecutive sampled cycles with BUSYWAIT high; ends sampling in the first low cycle.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.BUSYWAIT === 1'b1 && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic access(input logic rd, input logic blk, input logic [7:0] addr,
                          input logic [31:0] wdata, output int edges, output logic [31:0] rdata);
        @(negedge clk);
        bus.READ      = rd;
        bus.WRITE     = ~rd;
        bus.BLOCK     = blk;
        bus.ADDRESS   = addr;
        bus.WRITEDATA = wdata;
        #1;
        count_busy(edges);
        rdata = bus.READDATA;
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    initial begin
        int          edges;
        int          lows;
        logic [31:0] rdata;

        vecs[0]  = '{1'b0, 1'b0, 8'h10, 32'h0000_00A5, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 8'h10, 32'h0000_0000, 32'h0000_00A5};
        vecs[2]  = '{1'b0, 1'b1, 8'h23, 32'h4433_2211, 32'h0000_00A5};
        vecs[3]  = '{1'b1, 1'b0, 8'h22, 32'h0000_0000, 32'h0000_0033};
        vecs[4]  = '{1'b1, 1'b1, 8'h21, 32'h0000_0000, 32'h4433_2211};
        vecs[5]  = '{1'b1, 1'b0, 8'h20, 32'h0000_0000, 32'h0000_0011};
        vecs[6]  = '{1'b1, 1'b0, 8'h23, 32'h0000_0000, 32'h0000_0044};
        vecs[7]  = '{1'b0, 1'b1, 8'hFF, 32'hDDCC_BBAA, 32'h0000_0044};
        vecs[8]  = '{1'b1, 1'b0, 8'hFC, 32'h0000_0000, 32'h0000_00AA};
        vecs[9]  = '{1'b1, 1'b1, 8'hFE, 32'h0000_0000, 32'hDDCC_BBAA};
        vecs[10] = '{1'b0, 1'b0, 8'h30, 32'hFFFF_FF77, 32'hDDCC_BBAA};
        vecs[11] = '{1'b1, 1'b0, 8'h30, 32'h0000_0000, 32'h0000_0077};

        rst = 1'b0;
        bus.READ = 1'b0; bus.WRITE = 1'b0; bus.BLOCK = 1'b0;
        bus.ADDRESS = '0; bus.WRITEDATA = '0;
        #1;
        check("reset_readdata", bus.READDATA, 32'h0);
        check("reset_error", {31'b0, bus.ERROR}, 32'h0);
        bus.READ = 1'b1;
        #1;
        check("reset_busywait_gated", {31'b0, bus.BUSYWAIT}, 32'h0);
        bus.READ = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].rd, vecs[i].blk, vecs[i].addr, vecs[i].wdata, edges, rdata);
            check($sformatf("vec%0d_busy_edges", i), edges, 32'd6);
            check($sformatf("vec%0d_readdata", i), rdata, vecs[i].exp_rd);
        end

        // Reset asserted mid-cycle clears outputs without any clock edge.
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("midcycle_reset_readdata", bus.READDATA, 32'h0);
        check("midcycle_reset_busywait", {31'b0, bus.BUSYWAIT}, 32'h0);
        check("midcycle_reset_error", {31'b0, bus.ERROR}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Illegal request: READ and WRITE together.
        @(negedge clk);
        bus.READ = 1'b1; bus.WRITE = 1'b1; bus.ADDRESS = 8'h10;
        #1;
        check("illegal_busywait", {31'b0, bus.BUSYWAIT}, 32'h0);
        check("illegal_error_before_edge", {31'b0, bus.ERROR}, 32'h0);
        @(posedge clk); #1;
        bus.READ = 1'b0; bus.WRITE = 1'b0;
        check("illegal_error_pulse", {31'b0, bus.ERROR}, 32'h1);
        check("illegal_busywait_after", {31'b0, bus.BUSYWAIT}, 32'h0);
        @(posedge clk); #1;
        check("illegal_error_cleared", {31'b0, bus.ERROR}, 32'h0);
        access(1'b1, 1'b0, 8'h10, 32'h0, edges, rdata);
        check("illegal_then_read", rdata, 32'h0000_00A5);

        // Reset during BUSY (cnt==2) aborts a word write of 0x5A to 0x10.
        @(negedge clk);
        bus.WRITE = 1'b1; bus.BLOCK = 1'b0; bus.ADDRESS = 8'h10; bus.WRITEDATA = 32'h5A;
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("abort_busywait", {31'b0, bus.BUSYWAIT}, 32'h0);
        check("abort_readdata", bus.READDATA, 32'h0);
        bus.WRITE = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        access(1'b1, 1'b0, 8'h10, 32'h0, edges, rdata);
        check("abort_busy_edges", edges, 32'd6);
        check("abort_mem_kept", rdata, 32'h0000_00A5);

        // READ held through DONE restarts a second access.
        @(negedge clk);
        bus.READ = 1'b1; bus.WRITE = 1'b0; bus.BLOCK = 1'b0; bus.ADDRESS = 8'h10;
        #1;
        count_busy(edges);
        check("held_first_edges", edges, 32'd6);
        check("held_first_data", bus.READDATA, 32'h0000_00A5);
        lows = 0;
        while (bus.BUSYWAIT !== 1'b1 && lows < 10) begin
            lows++;
            @(negedge clk); #1;
        end
        check("held_low_cycles", lows, 32'd1);
        count_busy(edges);
        check("held_second_edges", edges, 32'd6);
        check("held_second_data", bus.READDATA, 32'h0000_00A5);
        bus.READ = 1'b0;
        @(negedge clk); #1;
        check("held_released_idle", {31'b0, bus.BUSYWAIT}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
